data_break_ctrl: RTL and testbench

Data-break (DMA) initiator for the PDP-8e core. It requests memory cycles from the CPU state machine via `data_break`/`to_disk`, follows the DB0→DB1→DB2 break states it returns, and supplies the 15-bit address and write data. It also captures read data, and streams words to or from a peripheral (disk controller) over a valid/ready handshake. It is the requesting end of the data-break interface the state machine services.

---
 rtl/data_break_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_data_break_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_break_ctrl.sv
`timescale 1ns/1ps
// data_break_ctrl: data-break (DMA) initiator for the PDP-8e core.
// Requests break cycles from the CPU state machine, drives the break address
// and write data, captures read data, and streams words to/from a peripheral
// over valid/ready handshakes. Bit 0 is the MSB on all PDP-8 style buses.
module data_break_ctrl #(
  parameter logic [4:0] DB0 = 5'd20,
  parameter logic [4:0] DB1 = 5'd21,
  parameter logic [4:0] DB2 = 5'd22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir_to_dev,
  input  logic [0:14] start_addr,
  input  logic [0:11] word_count,
  input  logic        abort,
  input  logic [4:0]  state,
  input  logic [0:11] mem_dout,
  input  logic        src_valid,
  input  logic [0:11] src_data,
  output logic        src_ready,
  output logic        snk_valid,
  output logic [0:11] snk_data,
  input  logic        snk_ready,
  output logic        data_break,
  output logic        to_disk,
  output logic [0:14] db_addr,
  output logic [0:11] db_data,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_BREAK,
    S_DELIVER,
    S_FINISH
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [0:14] addr_q, addr_d;
  logic [0:11] count_q, count_d;
  logic        dir_q, dir_d;
  logic [0:11] wdata_q, wdata_d;
  logic [0:11] rdata_q, rdata_d;
  logic        aborted_q, aborted_d;
  logic        data_break_q, data_break_d;
  logic        src_ready_q, src_ready_d;
  logic        snk_valid_q, snk_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // The CPU is inside a break cycle while it reports any of DB0..DB2.
  logic in_break;
  // Count register after this word's decrement reaches zero.
  logic last_word;
  // Handshakes complete on any edge where both sides agree.
  logic src_hs;
  logic snk_hs;

  assign in_break  = (state == DB0) || (state == DB1) || (state == DB2);
  assign last_word = (count_q == 12'd1);
  assign src_hs    = src_valid && src_ready_q;
  assign snk_hs    = snk_valid_q && snk_ready;

  // Next-state and datapath update; every target holds its value by default.
  always_comb begin
    fsm_d     = fsm_q;
    addr_d    = addr_q;
    count_d   = count_q;
    dir_d     = dir_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aborted_d = aborted_q;

    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = start_addr;
          count_d   = word_count;
          dir_d     = dir_to_dev;
          aborted_d = 1'b0;
          fsm_d     = dir_to_dev ? S_REQ : S_FETCH;
        end
      end

      S_FETCH: begin
        // Abort wins over a word offered in the same cycle: nothing has
        // been committed to memory for it yet, so it is simply dropped.
        if (abort) begin
          aborted_d = 1'b1;
          fsm_d     = S_FINISH;
        end else if (src_hs) begin
          wdata_d = src_data;
          fsm_d   = S_REQ;
        end
      end

      S_REQ: begin
        // Once requested the word always completes; abort is not looked at.
        if (state == DB0) begin
          fsm_d = S_BREAK;
        end
      end

      S_BREAK: begin
        if (dir_q && (state == DB2)) begin
          rdata_d = mem_dout;
        end
        // First cycle after the break: advance address within the field
        // (field bits 0:2 never change) and consume one word of the count.
        if (!in_break) begin
          addr_d[3:14] = addr_q[3:14] + 12'd1;
          count_d      = count_q - 12'd1;
          if (dir_q) begin
            fsm_d = S_DELIVER;
          end else if (last_word) begin
            fsm_d = S_FINISH;
          end else if (abort) begin
            aborted_d = 1'b1;
            fsm_d     = S_FINISH;
          end else begin
            fsm_d = S_FETCH;
          end
        end
      end

      S_DELIVER: begin
        // The count was already decremented on leaving the break cycle.
        if (snk_hs) begin
          if (count_q == 12'd0) begin
            fsm_d = S_FINISH;
          end else if (abort) begin
            aborted_d = 1'b1;
            fsm_d     = S_FINISH;
          end else begin
            fsm_d = S_REQ;
          end
        end
      end

      S_FINISH: begin
        fsm_d = S_IDLE;
      end

      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // Control outputs are registered from the next state so each one is
  // glitch-free and lines up with the state it describes.
  always_comb begin
    data_break_d = (fsm_d == S_REQ);
    src_ready_d  = (fsm_d == S_FETCH);
    snk_valid_d  = (fsm_d == S_DELIVER);
    busy_d       = (fsm_d == S_FETCH) || (fsm_d == S_REQ) ||
                   (fsm_d == S_BREAK) || (fsm_d == S_DELIVER);
    done_d       = (fsm_d == S_FINISH);
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q        <= S_IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      dir_q        <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      aborted_q    <= 1'b0;
      data_break_q <= 1'b0;
      src_ready_q  <= 1'b0;
      snk_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      dir_q        <= dir_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      aborted_q    <= aborted_d;
      data_break_q <= data_break_d;
      src_ready_q  <= src_ready_d;
      snk_valid_q  <= snk_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data_break = data_break_q;
  assign to_disk    = dir_q;
  assign db_addr    = addr_q;
  assign db_data    = wdata_q;
  assign snk_data   = rdata_q;
  assign src_ready  = src_ready_q;
  assign snk_valid  = snk_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_data_break_ctrl.sv
`timescale 1ns/1ps
// tb_data_break_ctrl: directed bench with a small CPU break-cycle model,
// a memory image, and monitors that log break addresses and sink words.
module tb_data_break_ctrl;

  localparam logic [4:0] DB0    = 5'd20;
  localparam logic [4:0] DB1    = 5'd21;
  localparam logic [4:0] DB2    = 5'd22;
  localparam logic [4:0] ST_RUN = 5'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dir_to_dev;
  logic [0:14] start_addr;
  logic [0:11] word_count;
  logic        abort;
  logic [4:0]  cpu_state;
  logic [0:11] mem_dout;
  logic        src_valid;
  logic [0:11] src_data;
  logic        src_ready;
  logic        snk_valid;
  logic [0:11] snk_data;
  logic        snk_ready;
  logic        data_break;
  logic        to_disk;
  logic [0:14] db_addr;
  logic [0:11] db_data;
  logic        busy;
  logic        done;
  logic        aborted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:11] mem_rd [0:32767];
  logic [0:11] mem_wr [0:32767];

  always #5 clk = ~clk;

  data_break_ctrl #(.DB0(DB0), .DB1(DB1), .DB2(DB2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dir_to_dev (dir_to_dev),
    .start_addr (start_addr),
    .word_count (word_count),
    .abort      (abort),
    .state      (cpu_state),
    .mem_dout   (mem_dout),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .snk_valid  (snk_valid),
    .snk_data   (snk_data),
    .snk_ready  (snk_ready),
    .data_break (data_break),
    .to_disk    (to_disk),
    .db_addr    (db_addr),
    .db_data    (db_data),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  // CPU model: grants a break DB0->DB1->DB2, memory access during DB1.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_state <= 5'd0;
      mem_dout  <= '0;
    end else begin
      case (cpu_state)
        DB0: cpu_state <= DB1;
        DB1: begin
          cpu_state <= DB2;
          if (to_disk) mem_dout <= mem_rd[db_addr];
          else         mem_wr[db_addr] <= db_data;
        end
        DB2:     cpu_state <= ST_RUN;
        default: cpu_state <= data_break ? DB0 : ST_RUN;
      endcase
    end
  end

  // Monitors: counters and logs only ever written here.
  logic        db_prev = 1'b0;
  int          brk_cnt = 0, db_rise_cnt = 0, wr_rise_cnt = 0, src_hs_cnt = 0;
  int          done_cnt = 0, early_cnt = 0, unstable_cnt = 0;
  logic [0:14] rise_addr = '0;
  logic [0:11] rise_data = '0;
  logic [0:14] addr_log [$];
  logic [0:11] snk_log [$];

  always @(posedge clk) begin
    if (reset) begin
      if (data_break && !db_prev) begin
        db_rise_cnt <= db_rise_cnt + 1;
        rise_addr   <= db_addr;
        rise_data   <= db_data;
        if (!to_disk) begin
          wr_rise_cnt <= wr_rise_cnt + 1;
          if (wr_rise_cnt + 1 > src_hs_cnt) early_cnt <= early_cnt + 1;
        end
      end
      if (cpu_state == DB0 || cpu_state == DB1 || cpu_state == DB2) begin
        if (db_addr !== rise_addr || (!to_disk && db_data !== rise_data))
          unstable_cnt <= unstable_cnt + 1;
      end
      if (cpu_state == DB0) begin
        brk_cnt <= brk_cnt + 1;
        addr_log.push_back(db_addr);
      end
      if (snk_valid && snk_ready) snk_log.push_back(snk_data);
      if (src_valid && src_ready) src_hs_cnt <= src_hs_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
    db_prev <= data_break;
  end

  task automatic do_start(input logic dir, input logic [0:14] a, input logic [0:11] c);
    @(negedge clk);
    start = 1'b1; dir_to_dev = dir; start_addr = a; word_count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic feed_word(input logic [0:11] w, input int delay, output bit ok);
    int base;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (src_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    repeat (delay) @(negedge clk);
    src_valid = 1'b1; src_data = w; base = src_hs_cnt; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (src_hs_cnt != base) begin ok = 1'b1; break; end
    end
    src_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, data_break, src_ready, snk_valid, to_disk, aborted} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 0000000",
               {busy, done, data_break, src_ready, snk_valid, to_disk, aborted});
    end
    n_checks++;
    if ({db_addr, db_data, snk_data} !== 39'b0) begin
      n_fail++;
      $display("FAIL reset_data: addr %o data %o snk %o, want 0", db_addr, db_data, snk_data);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b, want 0", busy); end
    $display("reset: released, controller idle");
  endtask

  task automatic test_read3();
    logic [0:14] exp_a [3];
    logic [0:11] exp_d [3];
    int b_brk, b_addr, b_snk, b_done;
    bit ok;
    exp_a = '{15'o10200, 15'o10201, 15'o10202};
    exp_d = '{12'o1111, 12'o2222, 12'o3333};
    for (int i = 0; i < 3; i++) mem_rd[exp_a[i]] = exp_d[i];
    b_brk = brk_cnt; b_addr = addr_log.size(); b_snk = snk_log.size(); b_done = done_cnt;
    snk_ready = 1'b1;
    do_start(1'b1, 15'o10200, 12'd3);
    n_checks++;
    if ({busy, data_break, to_disk} !== 3'b111) begin
      n_fail++; $display("FAIL read3_first_cycle: busy/db/to_disk %b, want 111", {busy, data_break, to_disk});
    end
    wait_done(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL read3_timeout: done not seen, want done"); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (brk_cnt - b_brk !== 3) begin n_fail++; $display("FAIL read3_breaks: got %0d, want 3", brk_cnt - b_brk); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (addr_log.size() <= b_addr + i) begin
        n_fail++; $display("FAIL read3_addr%0d: missing, want %o", i, exp_a[i]);
      end else if (addr_log[b_addr + i] !== exp_a[i]) begin
        n_fail++; $display("FAIL read3_addr%0d: got %o, want %o", i, addr_log[b_addr + i], exp_a[i]);
      end
      n_checks++;
      if (snk_log.size() <= b_snk + i) begin
        n_fail++; $display("FAIL read3_data%0d: missing, want %o", i, exp_d[i]);
      end else if (snk_log[b_snk + i] !== exp_d[i]) begin
        n_fail++; $display("FAIL read3_data%0d: got %o, want %o", i, snk_log[b_snk + i], exp_d[i]);
      end
    end
    n_checks++;
    if (done_cnt - b_done !== 1) begin n_fail++; $display("FAIL read3_done: got %0d pulses, want 1", done_cnt - b_done); end
    n_checks++;
    if (aborted !== 1'b0) begin n_fail++; $display("FAIL read3_aborted: got %b, want 0", aborted); end
    $display("read3: 3 words from 10200 transferred");
  endtask

  task automatic test_write2();
    int b_addr, b_early, b_unst, b_done;
    bit ok;
    b_addr = addr_log.size(); b_early = early_cnt; b_unst = unstable_cnt; b_done = done_cnt;
    do_start(1'b0, 15'o00007, 12'd2);
    feed_word(12'o4321, 5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL write2_word0_hs: no handshake, want handshake"); end
    feed_word(12'o1234, 5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL write2_word1_hs: no handshake, want handshake"); end
    wait_done(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL write2_timeout: done not seen, want done"); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (mem_wr[15'o00007] !== 12'o4321) begin n_fail++; $display("FAIL write2_mem7: got %o, want 4321", mem_wr[15'o00007]); end
    n_checks++;
    if (mem_wr[15'o00010] !== 12'o1234) begin n_fail++; $display("FAIL write2_mem10: got %o, want 1234", mem_wr[15'o00010]); end
    n_checks++;
    if (early_cnt - b_early !== 0) begin n_fail++; $display("FAIL write2_early_break: got %0d, want 0", early_cnt - b_early); end
    n_checks++;
    if (unstable_cnt - b_unst !== 0) begin n_fail++; $display("FAIL write2_stable: got %0d changes, want 0", unstable_cnt - b_unst); end
    n_checks++;
    if (addr_log.size() != b_addr + 2 || addr_log[b_addr + 1] !== 15'o00010) begin
      n_fail++; $display("FAIL write2_addr: got %0d breaks, want 2 ending at 00010", addr_log.size() - b_addr);
    end
    n_checks++;
    if (done_cnt - b_done !== 1) begin n_fail++; $display("FAIL write2_done: got %0d pulses, want 1", done_cnt - b_done); end
    $display("write2: 4321,1234 written to 00007,00010");
  endtask

  task automatic test_wrap();
    int b_addr;
    bit ok;
    b_addr = addr_log.size();
    do_start(1'b0, 15'o27777, 12'd2);
    feed_word(12'o0101, 0, ok);
    feed_word(12'o0202, 0, ok);
    wait_done(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wrap_timeout: done not seen, want done"); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (addr_log.size() != b_addr + 2 || addr_log[b_addr] !== 15'o27777 || addr_log[b_addr + 1] !== 15'o20000) begin
      n_fail++; $display("FAIL wrap_addr: got %0d breaks, want 27777 then 20000", addr_log.size() - b_addr);
    end
    n_checks++;
    if (mem_wr[15'o27777] !== 12'o0101 || mem_wr[15'o20000] !== 12'o0202) begin
      n_fail++; $display("FAIL wrap_mem: got %o/%o, want 0101/0202", mem_wr[15'o27777], mem_wr[15'o20000]);
    end
    $display("wrap: 27777 -> 20000 within field 2");
  endtask

  task automatic test_abort();
    int b_brk, b_snk, b_done, b_rise;
    bit ok;
    for (int i = 0; i < 8; i++) mem_rd[15'o00100 + i] = 12'o0700 + 12'(i);
    b_brk = brk_cnt; b_snk = snk_log.size(); b_done = done_cnt; b_rise = db_rise_cnt;
    snk_ready = 1'b1;
    do_start(1'b1, 15'o00100, 12'd0);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!abort && data_break && (db_rise_cnt - b_rise == 4)) abort = 1'b1;
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL abort_timeout: done not seen, want done"); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (brk_cnt - b_brk !== 4) begin n_fail++; $display("FAIL abort_breaks: got %0d, want 4", brk_cnt - b_brk); end
    n_checks++;
    if (snk_log.size() - b_snk !== 4) begin
      n_fail++; $display("FAIL abort_words: got %0d, want 4", snk_log.size() - b_snk);
    end else if (snk_log[b_snk + 3] !== 12'o0703) begin
      n_fail++; $display("FAIL abort_last_word: got %o, want 0703", snk_log[b_snk + 3]);
    end
    n_checks++;
    if (aborted !== 1'b1) begin n_fail++; $display("FAIL abort_flag: got %b, want 1", aborted); end
    n_checks++;
    if (done_cnt - b_done !== 1) begin n_fail++; $display("FAIL abort_done: got %0d pulses, want 1", done_cnt - b_done); end
    abort = 1'b0;
    $display("abort: stopped after 4 words of 4096");
  endtask

  task automatic test_stall();
    int b_brk, b_addr, b_snk, held_bad;
    bit ok;
    mem_rd[15'o00300] = 12'o5555;
    mem_rd[15'o00301] = 12'o6666;
    b_brk = brk_cnt; b_addr = addr_log.size(); b_snk = snk_log.size();
    snk_ready = 1'b0;
    do_start(1'b1, 15'o00300, 12'd2);
    n_checks++;
    if (aborted !== 1'b0) begin n_fail++; $display("FAIL stall_aborted_cleared: got %b, want 0", aborted); end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (snk_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_valid_timeout: snk_valid not seen, want 1"); end
    held_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!snk_valid || snk_data !== 12'o5555 || data_break || !busy) held_bad++;
      if (i == 5) begin start = 1'b1; dir_to_dev = 1'b0; start_addr = 15'o07000; word_count = 12'd5; end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (held_bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles, want 0", held_bad); end
    snk_ready = 1'b1;
    wait_done(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_timeout: done not seen, want done"); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (snk_log.size() != b_snk + 2 || snk_log[b_snk] !== 12'o5555 || snk_log[b_snk + 1] !== 12'o6666) begin
      n_fail++; $display("FAIL stall_data: got %0d words, want 5555,6666", snk_log.size() - b_snk);
    end
    n_checks++;
    if (brk_cnt - b_brk !== 2 || addr_log.size() != b_addr + 2 || addr_log[b_addr + 1] !== 15'o00301) begin
      n_fail++; $display("FAIL stall_breaks: got %0d breaks, want 2 ending at 00301", brk_cnt - b_brk);
    end
    $display("stall: sink held 20 cycles, busy start ignored");
  endtask

  task automatic test_reset_mid();
    int b_addr, b_snk, b_done;
    bit ok;
    snk_ready = 1'b1;
    do_start(1'b1, 15'o00400, 12'd1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cpu_state == DB1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_break: busy %b, want 1 in DB1", busy); end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, data_break, src_ready, snk_valid, to_disk, aborted, db_addr, db_data, snk_data} !== 46'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: busy %b to_disk %b addr %o, want all 0", busy, to_disk, db_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_rd[15'o00500] = 12'o7070;
    b_addr = addr_log.size(); b_snk = snk_log.size(); b_done = done_cnt;
    do_start(1'b1, 15'o00500, 12'd1);
    wait_done(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: done not seen, want done"); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (snk_log.size() != b_snk + 1 || snk_log[b_snk] !== 12'o7070) begin
      n_fail++; $display("FAIL rstmid_data: got %0d words, want one 7070", snk_log.size() - b_snk);
    end
    n_checks++;
    if (addr_log.size() != b_addr + 1 || addr_log[b_addr] !== 15'o00500) begin
      n_fail++; $display("FAIL rstmid_addr: got %0d breaks, want one at 00500", addr_log.size() - b_addr);
    end
    n_checks++;
    if (done_cnt - b_done !== 1 || aborted !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_done: got %0d pulses aborted %b, want 1 and 0", done_cnt - b_done, aborted);
    end
    $display("reset_mid: recovered, 1 word 7070 from 00500");
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dir_to_dev = 1'b0; start_addr = '0; word_count = '0;
    abort = 1'b0; src_valid = 1'b0; src_data = '0; snk_ready = 1'b0;
    for (int i = 0; i < 32768; i++) begin mem_rd[i] = '0; mem_wr[i] = '0; end
    test_reset();
    test_read3();
    test_write2();
    test_wrap();
    test_abort();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
